// File: rtl/phy_free_list.sv
// -----------------------------------------------------------------------------
// phy_free_list
//   Circular FIFO of unallocated physical register tags for a dual-issue rename
//   stage. Up to two tags are offered and consumed per cycle. The superseded
//   tags of up to two committed instructions are taken back per cycle.
//
// Ports
//   clk, rst_n                 clock; asynchronous active-low reset
//   alloc_first_i/second_i     rename slots 0/1 consume a tag this cycle
//   free_list_rdata_first      tag offered to slot 0 (mem[head])
//   free_list_rdata_second     tag offered to slot 1 (mem[head+1] when slot 0
//                              also allocates, otherwise mem[head])
//   alloc_avail_o              tags grantable this cycle, min(count, 2)
//   release_first_i/_addr_i    commit slot 0 returns a tag
//   release_second_i/_addr_i   commit slot 1 returns a tag
//   free_count_o               number of tags currently held
//   underflow_err_o            sticky: more allocations requested than held
//   overflow_err_o             sticky: a release found no room in the list
// -----------------------------------------------------------------------------
module phy_free_list #(
    parameter int unsigned PHY_REG_NUM        = 64,
    parameter int unsigned PHY_REG_ADDR_WIDTH = 6,
    parameter int unsigned RESERVED_NUM       = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alloc_first_i,
    input  logic                          alloc_second_i,
    output logic [PHY_REG_ADDR_WIDTH-1:0] free_list_rdata_first,
    output logic [PHY_REG_ADDR_WIDTH-1:0] free_list_rdata_second,
    output logic [1:0]                    alloc_avail_o,
    input  logic                          release_first_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] release_first_addr_i,
    input  logic                          release_second_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] release_second_addr_i,
    output logic [PHY_REG_ADDR_WIDTH:0]   free_count_o,
    output logic                          underflow_err_o,
    output logic                          overflow_err_o
);

    localparam int unsigned AW = PHY_REG_ADDR_WIDTH;
    localparam int unsigned CW = PHY_REG_ADDR_WIDTH + 1;
    localparam int unsigned INIT_COUNT = PHY_REG_NUM - RESERVED_NUM;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [AW-1:0] mem_q [PHY_REG_NUM];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          uf_q, uf_d;
    logic          of_q, of_d;

    // ---------------------------------------------------------------------
    // Pop / push decode
    // ---------------------------------------------------------------------
    logic          grant_first, grant_second;
    logic [1:0]    n_grant;
    logic          valid_first, valid_second;
    logic          acc_first, acc_second;
    logic [1:0]    n_push;
    logic [CW-1:0] room;
    logic          we0, we1;
    logic [AW-1:0] wa0, wa1;
    logic [AW-1:0] head_p1;

    always_comb begin
        head_p1 = head_q + AW'(1);

        // Zero-latency read; a lone slot-1 allocation takes the head entry.
        free_list_rdata_first  = mem_q[head_q];
        free_list_rdata_second = alloc_first_i ? mem_q[head_p1] : mem_q[head_q];

        alloc_avail_o = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];

        // Slot 0 has priority; slot 1 needs a second entry only if slot 0 also pops.
        grant_first  = alloc_first_i && (count_q != '0);
        grant_second = alloc_second_i &&
                       (alloc_first_i ? (count_q >= CW'(2)) : (count_q != '0));
        n_grant      = {1'b0, grant_first} + {1'b0, grant_second};

        // Reserved tags are never returned to the list.
        valid_first  = release_first_i  && (release_first_addr_i  >= AW'(RESERVED_NUM));
        valid_second = release_second_i && (release_second_addr_i >= AW'(RESERVED_NUM));

        // Room counts entries vacated by this cycle's pops, so a full list can
        // pop two and push two in the same cycle.
        room       = CW'(PHY_REG_NUM) - (count_q - CW'(n_grant));
        acc_first  = valid_first && (room >= CW'(1));
        acc_second = valid_second && (room >= (acc_first ? CW'(2) : CW'(1)));
        n_push     = {1'b0, acc_first} + {1'b0, acc_second};

        we0 = acc_first;
        wa0 = tail_q;
        we1 = acc_second;
        wa1 = acc_first ? (tail_q + AW'(1)) : tail_q;

        head_d  = head_q + AW'(n_grant);
        tail_d  = tail_q + AW'(n_push);
        count_d = count_q - CW'(n_grant) + CW'(n_push);

        uf_d = uf_q || (alloc_first_i && !grant_first) || (alloc_second_i && !grant_second);
        of_d = of_q || (valid_first && !acc_first) || (valid_second && !acc_second);
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= AW'(INIT_COUNT);
            count_q <= CW'(INIT_COUNT);
            uf_q    <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            uf_q    <= uf_d;
            of_q    <= of_d;
        end
    end

    // wa0 and wa1 never collide: a second write only lands at tail+1 when the
    // first write also happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PHY_REG_NUM; i++) begin
                mem_q[i] <= (i < INIT_COUNT) ? AW'(i + RESERVED_NUM) : '0;
            end
        end else begin
            if (we0) mem_q[wa0] <= release_first_addr_i;
            if (we1) mem_q[wa1] <= release_second_addr_i;
        end
    end

    assign free_count_o    = count_q;
    assign underflow_err_o = uf_q;
    assign overflow_err_o  = of_q;

endmodule

// File: tb/tb_phy_free_list.sv
module tb_phy_free_list;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       af, as1;
    logic [5:0] rd0, rd1;
    logic [1:0] avail;
    logic       rf, rs;
    logic [5:0] rfa, rsa;
    logic [6:0] cnt;
    logic       uf, of;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    phy_free_list #(
        .PHY_REG_NUM(64),
        .PHY_REG_ADDR_WIDTH(6),
        .RESERVED_NUM(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .alloc_first_i(af),
        .alloc_second_i(as1),
        .free_list_rdata_first(rd0),
        .free_list_rdata_second(rd1),
        .alloc_avail_o(avail),
        .release_first_i(rf),
        .release_first_addr_i(rfa),
        .release_second_i(rs),
        .release_second_addr_i(rsa),
        .free_count_o(cnt),
        .underflow_err_o(uf),
        .overflow_err_o(of)
    );

    typedef struct {
        logic       a0, a1, r0;
        logic [5:0] r0a;
        logic       r1;
        logic [5:0] r1a;
        logic [5:0] e_rd0, e_rd1;
        logic [1:0] e_av;
        logic [6:0] e_cnt;
        logic       e_uf, e_of;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle();
        af = 0; as1 = 0; rf = 0; rs = 0; rfa = '0; rsa = '0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after posedge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #13;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic drain_pairs(input int n);
        for (int k = 0; k < n; k++) begin
            af = 1; as1 = 1;
            cyc();
        end
        idle();
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        idle();

        // a0 a1 r0 r0a r1 r1a | rd0 rd1 av cnt uf of  (outputs before the edge)
        vecs[0] = '{0, 0, 0, 6'd0, 0, 6'd0,  6'd1, 6'd1, 2'd2, 7'd63, 0, 0};
        vecs[1] = '{1, 1, 0, 6'd0, 0, 6'd0,  6'd1, 6'd2, 2'd2, 7'd63, 0, 0};
        vecs[2] = '{1, 1, 0, 6'd0, 0, 6'd0,  6'd3, 6'd4, 2'd2, 7'd61, 0, 0};
        vecs[3] = '{1, 1, 0, 6'd0, 0, 6'd0,  6'd5, 6'd6, 2'd2, 7'd59, 0, 0};
        vecs[4] = '{0, 0, 0, 6'd0, 0, 6'd0,  6'd7, 6'd7, 2'd2, 7'd57, 0, 0};
        vecs[5] = '{0, 1, 0, 6'd0, 0, 6'd0,  6'd7, 6'd7, 2'd2, 7'd57, 0, 0};
        vecs[6] = '{1, 0, 0, 6'd0, 0, 6'd0,  6'd8, 6'd9, 2'd2, 7'd56, 0, 0};
        vecs[7] = '{0, 0, 1, 6'd0, 1, 6'd3,  6'd9, 6'd9, 2'd2, 7'd55, 0, 0};
        vecs[8] = '{0, 0, 0, 6'd0, 0, 6'd0,  6'd9, 6'd9, 2'd2, 7'd56, 0, 0};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            af = vecs[i].a0; as1 = vecs[i].a1;
            rf = vecs[i].r0; rfa = vecs[i].r0a;
            rs = vecs[i].r1; rsa = vecs[i].r1a;
            #1;
            chk($sformatf("v%0d rd0", i), rd0, vecs[i].e_rd0);
            chk($sformatf("v%0d rd1", i), rd1, vecs[i].e_rd1);
            chk($sformatf("v%0d avail", i), avail, vecs[i].e_av);
            chk($sformatf("v%0d count", i), cnt, vecs[i].e_cnt);
            chk($sformatf("v%0d uf", i), uf, vecs[i].e_uf);
            chk($sformatf("v%0d of", i), of, vecs[i].e_of);
            cyc();
        end
        idle();

        // Lone slot-1 allocation after reset takes the head tag.
        do_reset();
        as1 = 1; #1;
        chk("lone2 rd1", rd1, 6'd1);
        cyc();
        idle(); #1;
        chk("lone2 next rd0", rd0, 6'd2);
        chk("lone2 count", cnt, 7'd62);

        // Drain to one entry, then over-request.
        do_reset();
        drain_pairs(31);
        chk("drain count", cnt, 7'd1);
        chk("drain avail", avail, 2'd1);
        chk("drain rd0", rd0, 6'd63);
        chk("drain uf clear", uf, 1'b0);
        af = 1; as1 = 1;
        cyc();
        idle(); #1;
        chk("under uf", uf, 1'b1);
        chk("under count", cnt, 7'd0);
        chk("under avail", avail, 2'd0);

        // Empty: release two while slot 0 asks; no bypass, tail wraps 63->0.
        af = 1; rf = 1; rfa = 6'd40; rs = 1; rsa = 6'd41;
        #1;
        chk("empty avail", avail, 2'd0);
        cyc();
        idle(); af = 1; #1;
        chk("refill count", cnt, 7'd2);
        chk("refill rd0", rd0, 6'd40);
        chk("refill rd1", rd1, 6'd41);
        chk("refill uf sticky", uf, 1'b1);
        idle();

        // Reserved tag dropped; overflow at full; full pop2+push2; head wrap.
        do_reset();
        rf = 1; rfa = 6'd0;
        cyc();
        idle(); #1;
        chk("rsv count", cnt, 7'd63);
        chk("rsv of", of, 1'b0);
        rf = 1; rfa = 6'd10; rs = 1; rsa = 6'd20;
        cyc();
        idle(); #1;
        chk("ovf count", cnt, 7'd64);
        chk("ovf of", of, 1'b1);
        af = 1; as1 = 1; rf = 1; rfa = 6'd30; rs = 1; rsa = 6'd31;
        #1;
        chk("full rd0", rd0, 6'd1);
        chk("full rd1", rd1, 6'd2);
        cyc();
        idle(); #1;
        chk("full swap count", cnt, 7'd64);
        chk("full swap of sticky", of, 1'b1);
        drain_pairs(30);
        chk("wrap count pre", cnt, 7'd4);
        af = 1; #1;
        chk("wrap rd0 pre", rd0, 6'd63);
        chk("wrap rd1 pre", rd1, 6'd10);
        as1 = 1;
        cyc();
        idle(); af = 1; #1;
        chk("wrap count", cnt, 7'd2);
        chk("wrap rd0", rd0, 6'd30);
        chk("wrap rd1", rd1, 6'd31);
        chk("wrap uf clear", uf, 1'b0);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
